twi_init_sequencer: RTL and testbench

Autonomous bus master that sits directly upstream of the PLB TWI master logic and drives its slave register interface in place of the processor. On start it programs the clock divider, then walks an external command ROM of {device address, register, value} triplets and issues one two-byte TWI register write per entry. Used to bring up the ML505 video decoder/encoder over I2C before software runs. Reports completion, NACK and timeout errors, and the failing entry index.

---
 rtl/twi_init_if.sv | 25 ++
 rtl/twi_init_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_twi_init_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/twi_init_if.sv
// Register-slave bus between the init sequencer and the PLB TWI master logic.
// Handshake: the master holds exactly one CE bit high, with data/BE stable, until the
// matching ack (WrAck for WrCE, RdAck for RdCE) is sampled high; CE drops the next cycle.
interface twi_init_if #(
  parameter int PLB_DATA_WIDTH = 32,
  parameter int REG_COUNT      = 5
);
  logic [PLB_DATA_WIDTH-1:0]   oPlbData;
  logic [PLB_DATA_WIDTH/8-1:0] oPlbBE;
  logic [REG_COUNT-1:0]        oPlbRdCE;
  logic [REG_COUNT-1:0]        oPlbWrCE;
  logic [PLB_DATA_WIDTH-1:0]   iPlbData;
  logic                        iPlbRdAck;
  logic                        iPlbWrAck;

  modport master (
    output oPlbData, oPlbBE, oPlbRdCE, oPlbWrCE,
    input  iPlbData, iPlbRdAck, iPlbWrAck
  );

  modport slave (
    input  oPlbData, oPlbBE, oPlbRdCE, oPlbWrCE,
    output iPlbData, iPlbRdAck, iPlbWrAck
  );
endinterface

// File: rtl/twi_init_sequencer.sv
// Autonomous TWI bring-up master: programs the clock divider, then replays a command ROM
// of {dev, reg, val} triplets as two-byte TWI register writes, with NACK retry and timeout.
module twi_init_sequencer #(
  parameter int          PLB_DATA_WIDTH = 32,
  parameter int          REG_COUNT      = 5,
  parameter int          ROM_ADDR_WIDTH = 8,
  parameter logic [31:0] DIVIDER_VALUE  = 32'h00000005,
  parameter int          RETRIES        = 3,
  parameter int          TIMEOUT        = 65535
) (
  input  logic                      iPlbClk,
  input  logic                      iPlbReset,
  input  logic                      iStart,
  output logic [ROM_ADDR_WIDTH-1:0] oRomAddr,
  input  logic [23:0]               iRomData,
  twi_init_if.master                bus,
  output logic                      oBusy,
  output logic                      oDone,
  output logic                      oError,
  output logic [1:0]                oErrCode,
  output logic [ROM_ADDR_WIDTH-1:0] oErrIndex,
  output logic [3:0]                oDbgState
);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int BEW = PLB_DATA_WIDTH / 8;
  localparam logic [2:0] R_DATA_WRITE = 3'd0;
  localparam logic [2:0] R_ADDRESS    = 3'd2;
  localparam logic [2:0] R_CONTROL    = 3'd3;
  localparam logic [2:0] R_DIVIDER    = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_DIV, S_FETCH, S_LATCH, S_WR_ADDR, S_WR_REG, S_GO1, S_POLL1,
    S_WR_VAL, S_GO2, S_POLL2, S_RETRY, S_ERROR, S_FINISH
  } state_t;

  state_t                    state_q, state_d;
  logic                      req_q, req_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic [2:0]                retry_q, retry_d;
  logic [ROM_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [23:0]               entry_q, entry_d;
  logic                      done_q, done_d, error_q, error_d;
  logic [1:0]                code_q, code_d;
  logic [ROM_ADDR_WIDTH-1:0] err_idx_q, err_idx_d;

  logic                      is_bus, is_read, ack;
  logic [2:0]                acc_reg;
  logic [7:0]                wr_byte;
  logic [REG_COUNT-1:0]      ce_sel;
  logic                      unused_rd;

  // Per-state access decode: which register, which byte, read or write.
  always_comb begin
    is_bus  = 1'b1;
    is_read = 1'b0;
    acc_reg = R_CONTROL;
    wr_byte = 8'h00;
    case (state_q)
      S_WR_DIV:         acc_reg = R_DIVIDER;
      S_WR_ADDR: begin  acc_reg = R_ADDRESS;    wr_byte = entry_q[23:16] & 8'hFE; end
      S_WR_REG:  begin  acc_reg = R_DATA_WRITE; wr_byte = entry_q[15:8];          end
      S_GO1:            wr_byte = 8'hA0;
      S_WR_VAL:  begin  acc_reg = R_DATA_WRITE; wr_byte = entry_q[7:0];           end
      S_GO2:            wr_byte = 8'h80;
      S_POLL1, S_POLL2: is_read = 1'b1;
      default:          is_bus  = 1'b0;
    endcase
  end

  // CE index 0 is the MSB of the CE vector, matching the big-endian PLB numbering.
  assign ce_sel    = {1'b1, {(REG_COUNT-1){1'b0}}} >> acc_reg;
  assign ack       = is_read ? bus.iPlbRdAck : bus.iPlbWrAck;
  assign unused_rd = ^{bus.iPlbData[PLB_DATA_WIDTH-1:8], bus.iPlbData[6:5],
                       bus.iPlbData[3], bus.iPlbData[1:0]};

  always_comb begin
    bus.oPlbWrCE = '0;
    bus.oPlbRdCE = '0;
    bus.oPlbData = '0;
    bus.oPlbBE   = '0;
    if (req_q && is_bus) begin
      if (is_read) begin
        bus.oPlbRdCE = ce_sel;
        bus.oPlbBE   = BEW'(1);
      end else begin
        bus.oPlbWrCE = ce_sel;
        // Byte registers live in the last (least significant) byte lane.
        bus.oPlbData = (state_q == S_WR_DIV) ? PLB_DATA_WIDTH'(DIVIDER_VALUE)
                                             : {{(PLB_DATA_WIDTH-8){1'b0}}, wr_byte};
        bus.oPlbBE   = (state_q == S_WR_DIV) ? '1 : BEW'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    retry_d   = retry_q;
    idx_d     = idx_q;
    entry_d   = entry_q;
    done_d    = done_q;
    error_d   = error_q;
    code_d    = code_q;
    err_idx_d = err_idx_q;
    case (state_q)
      S_IDLE: if (iStart) begin
        state_d   = S_WR_DIV;
        req_d     = 1'b0;
        idx_d     = '0;
        retry_d   = '0;
        done_d    = 1'b0;
        error_d   = 1'b0;
        code_d    = 2'd0;
        err_idx_d = '0;
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        entry_d = iRomData;
        if (iRomData[23:16] == 8'hFF) begin
          state_d   = S_FINISH;
          done_d    = 1'b1;
          err_idx_d = idx_q;
        end else begin
          state_d = S_WR_ADDR;
        end
      end
      S_RETRY: if (retry_q < 3'(RETRIES)) begin
        retry_d = retry_q + 3'd1;
        state_d = S_WR_ADDR;
      end else begin
        state_d   = S_ERROR;
        error_d   = 1'b1;
        code_d    = 2'd1;
        err_idx_d = idx_q;
      end
      S_ERROR, S_FINISH: state_d = S_IDLE;
      S_WR_DIV, S_WR_ADDR, S_WR_REG, S_GO1, S_POLL1, S_WR_VAL, S_GO2, S_POLL2: begin
        if (tmo_q == TW'(TIMEOUT)) begin
          state_d   = S_ERROR;
          req_d     = 1'b0;
          error_d   = 1'b1;
          code_d    = 2'd2;
          err_idx_d = idx_q;
        end else if (!req_q) begin
          req_d = 1'b1;
        end else if (ack) begin
          req_d = 1'b0;
          case (state_q)
            S_WR_DIV:  state_d = S_FETCH;
            S_WR_ADDR: state_d = S_WR_REG;
            S_WR_REG:  state_d = S_GO1;
            S_GO1:     state_d = S_POLL1;
            S_WR_VAL:  state_d = S_GO2;
            S_GO2:     state_d = S_POLL2;
            default: begin
              // Re-read CONTROL until START and BUSY are both clear.
              if (bus.iPlbData[7] || bus.iPlbData[4]) begin
                state_d = state_q;
              end else if (bus.iPlbData[2]) begin
                state_d = S_RETRY;
              end else if (state_q == S_POLL1) begin
                state_d = S_WR_VAL;
              end else begin
                retry_d = '0;
                if (idx_q == '1) begin
                  state_d   = S_FINISH;
                  done_d    = 1'b1;
                  err_idx_d = idx_q;
                end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_FETCH;
                end
              end
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Timeout budget restarts on every state change, and runs across POLL re-reads.
    tmo_d = (is_bus && state_d == state_q) ? tmo_q + 1'b1 : '0;
  end

  always_ff @(posedge iPlbClk) begin
    if (!iPlbReset) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      tmo_q     <= '0;
      retry_q   <= '0;
      idx_q     <= '0;
      entry_q   <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      code_q    <= 2'd0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      tmo_q     <= tmo_d;
      retry_q   <= retry_d;
      idx_q     <= idx_d;
      entry_q   <= entry_d;
      done_q    <= done_d;
      error_q   <= error_d;
      code_q    <= code_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign oRomAddr  = idx_q;
  assign oBusy     = (state_q != S_IDLE) && (state_q != S_ERROR) && (state_q != S_FINISH);
  assign oDone     = done_q;
  assign oError    = error_q;
  assign oErrCode  = code_q;
  assign oErrIndex = err_idx_q;
  assign oDbgState = state_q;
endmodule

// File: tb/tb_twi_init_sequencer.sv
// Bench for twi_init_sequencer: ROM model, ACK/NACK TWI-master register model and a
// scoreboard of expected register writes built from the ROM contents before each run.
module tb_twi_init_sequencer;
  localparam int          DW      = 32;
  localparam int          RC      = 5;
  localparam int          AW      = 8;
  localparam int          RETRIES = 3;
  localparam int          TIMEOUT = 100;
  localparam logic [31:0] DIV     = 32'h00000005;
  localparam logic [3:0]  ST_POLL2 = 4'd10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [23:0]   rom_data;
  logic          busy, done, error;
  logic [1:0]    code;
  logic [AW-1:0] err_idx;
  logic [3:0]    dbg;

  twi_init_if #(.PLB_DATA_WIDTH(DW), .REG_COUNT(RC)) bus ();

  twi_init_sequencer #(
    .PLB_DATA_WIDTH(DW), .REG_COUNT(RC), .ROM_ADDR_WIDTH(AW),
    .DIVIDER_VALUE(DIV), .RETRIES(RETRIES), .TIMEOUT(TIMEOUT)
  ) dut (
    .iPlbClk(clk), .iPlbReset(rst_n), .iStart(start),
    .oRomAddr(rom_addr), .iRomData(rom_data), .bus(bus),
    .oBusy(busy), .oDone(done), .oError(error), .oErrCode(code),
    .oErrIndex(err_idx), .oDbgState(dbg)
  );

  // ---------------- clock / reset / models ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] rom [0:255];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int          checks = 0;
  int          failures = 0;
  logic [38:0] exp_q[$];
  bit          nack_plan[$];
  bit          wr_stall = 1'b0;
  bit          nack_now = 1'b0;
  int          busy_left = 0;
  int          addr_writes = 0;
  int          last_wrack_cyc = 0;

  function automatic logic [38:0] pk(input int r, input logic [3:0] be, input logic [31:0] d);
    return {r[2:0], be, d};
  endfunction

  function automatic logic [38:0] wb(input int r, input logic [7:0] b);
    return pk(r, 4'b0001, {24'h0, b});
  endfunction

  function automatic int ce_index(input logic [RC-1:0] ce);
    for (int k = 0; k < RC; k++) if (ce[RC-1-k]) return k;
    return -1;
  endfunction

  // TWI master register model + scoreboard compare of every write.
  always @(negedge clk) begin
    logic [38:0] obs, exp;
    logic [7:0]  ctrl;
    int          r;
    if (!rst_n) begin
      bus.iPlbWrAck = 1'b0; bus.iPlbRdAck = 1'b0; bus.iPlbData = '0;
      nack_now = 1'b0; busy_left = 0;
    end else if (bus.iPlbWrAck || bus.iPlbRdAck) begin
      bus.iPlbWrAck = 1'b0; bus.iPlbRdAck = 1'b0;
    end else if (bus.oPlbWrCE != '0 && !wr_stall) begin
      r   = ce_index(bus.oPlbWrCE);
      obs = {r[2:0], bus.oPlbBE, bus.oPlbData};
      checks++;
      if ($countones(bus.oPlbWrCE) != 1) begin
        failures++; $display("FAIL wr_ce_onehot: got %b expected one bit set", bus.oPlbWrCE);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL bus_write_extra: got %h expected no write", obs);
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp) begin
          failures++; $display("FAIL bus_write: got reg=%0d be=%h data=%h expected reg=%0d be=%h data=%h",
                               obs[38:36], obs[35:32], obs[31:0], exp[38:36], exp[35:32], exp[31:0]);
        end
      end
      if (r == 2) addr_writes++;
      if (r == 3) begin
        nack_now  = (bus.oPlbData[7:0] == 8'hA0 && nack_plan.size() > 0) ? nack_plan.pop_front() : 1'b0;
        busy_left = $urandom_range(0, 2);
      end
      bus.iPlbWrAck  = 1'b1;
      last_wrack_cyc = cyc;
    end else if (bus.oPlbRdCE != '0) begin
      checks++;
      if (bus.oPlbRdCE !== RC'(1 << (RC-1-3))) begin
        failures++; $display("FAIL rd_ce: got %b expected CONTROL only", bus.oPlbRdCE);
      end
      ctrl = (busy_left > 1) ? 8'h90 : (busy_left == 1) ? 8'h10 : (nack_now ? 8'h04 : 8'h00);
      if (busy_left > 0) busy_left--;
      bus.iPlbData  = {24'h0, ctrl};
      bus.iPlbRdAck = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_rom_ff();
    for (int i = 0; i < 256; i++) rom[i] = 24'hFFFFFF;
  endtask

  // Reference model: expected write stream and final outcome from ROM + NACK plan.
  task automatic expect_run(output bit exp_err, output logic [AW-1:0] exp_index);
    int p, retries;
    bit nk, fin;
    logic [23:0] e;
    p = 0; fin = 1'b0; exp_err = 1'b0; exp_index = '0;
    exp_q.delete();
    exp_q.push_back(pk(4, 4'hF, DIV));
    for (int i = 0; i < 256 && !fin; i++) begin
      e = rom[i];
      if (e[23:16] == 8'hFF) begin
        exp_index = AW'(i); fin = 1'b1;
      end else begin
        retries = 0;
        while (1) begin
          exp_q.push_back(wb(2, e[23:16] & 8'hFE));
          exp_q.push_back(wb(0, e[15:8]));
          exp_q.push_back(wb(3, 8'hA0));
          nk = (p < nack_plan.size()) ? nack_plan[p] : 1'b0;
          p++;
          if (!nk) begin
            exp_q.push_back(wb(0, e[7:0]));
            exp_q.push_back(wb(3, 8'h80));
            break;
          end
          if (retries == RETRIES) begin
            exp_err = 1'b1; exp_index = AW'(i); fin = 1'b1;
            break;
          end
          retries++;
        end
        if (!fin && i == 255) begin exp_index = AW'(255); fin = 1'b1; end
      end
    end
  endtask

  task automatic pulse_start(output logic busy_seen);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    busy_seen = busy;
  endtask

  task automatic wait_end(input int budget, output int n, output bit to);
    n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < budget) begin
      @(negedge clk); n++;
    end
    to = !(done === 1'b1 || error === 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b expected 0", error); end
    checks++; if (code !== 2'd0) begin failures++; $display("FAIL reset_code: got %0d expected 0", code); end
    checks++; if (err_idx !== '0) begin failures++; $display("FAIL reset_err_idx: got %0d expected 0", err_idx); end
    checks++; if (rom_addr !== '0) begin failures++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
    checks++; if (bus.oPlbWrCE !== '0 || bus.oPlbRdCE !== '0) begin
      failures++; $display("FAIL reset_ce: got wr=%b rd=%b expected 0", bus.oPlbWrCE, bus.oPlbRdCE); end
    checks++; if (bus.oPlbData !== '0 || bus.oPlbBE !== '0) begin
      failures++; $display("FAIL reset_data: got %h/%h expected 0", bus.oPlbData, bus.oPlbBE); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_single_entry();
    bit e_err, to; logic [AW-1:0] e_idx; logic b; int n;
    fill_rom_ff(); rom[0] = 24'h4EA611;
    nack_plan.delete(); expect_run(e_err, e_idx);
    pulse_start(b);
    checks++; if (b !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", b); end
    wait_end(2000, n, to);
    checks++; if (to) begin failures++; $display("FAIL single_timeout: got no end after %0d cycles expected done", n); end
    checks++; if (done !== 1'b1 || error !== e_err) begin
      failures++; $display("FAIL single_status: got done=%b err=%b expected 1/0", done, error); end
    checks++; if (err_idx !== e_idx) begin failures++; $display("FAIL single_idx: got %0d expected %0d", err_idx, e_idx); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_writes: got %0d missing expected 0", exp_q.size()); end
  endtask

  task automatic test_empty_table();
    bit e_err, to; logic [AW-1:0] e_idx; logic b; int n, dt;
    fill_rom_ff();
    nack_plan.delete(); expect_run(e_err, e_idx);
    pulse_start(b);
    wait_end(200, n, to);
    dt = cyc - last_wrack_cyc;
    checks++; if (to || done !== 1'b1) begin failures++; $display("FAIL empty_done: got done=%b expected 1", done); end
    checks++; if (dt < 1 || dt > 10) begin failures++; $display("FAIL empty_latency: got %0d cycles expected 1..10", dt); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL empty_writes: got %0d missing expected 0", exp_q.size()); end
    checks++; if (err_idx !== e_idx) begin failures++; $display("FAIL empty_idx: got %0d expected %0d", err_idx, e_idx); end
  endtask

  task automatic test_nack_all();
    bit e_err, to; logic [AW-1:0] e_idx; logic b; int n;
    fill_rom_ff(); rom[0] = 24'h400102;
    nack_plan.delete(); repeat (8) nack_plan.push_back(1'b1);
    addr_writes = 0; expect_run(e_err, e_idx);
    pulse_start(b);
    wait_end(2000, n, to);
    checks++; if (to || error !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL nack_all_status: got err=%b done=%b expected 1/0", error, done); end
    checks++; if (code !== 2'd1) begin failures++; $display("FAIL nack_all_code: got %0d expected 1", code); end
    checks++; if (err_idx !== e_idx) begin failures++; $display("FAIL nack_all_idx: got %0d expected %0d", err_idx, e_idx); end
    checks++; if (addr_writes != RETRIES + 1) begin
      failures++; $display("FAIL nack_all_attempts: got %0d expected %0d", addr_writes, RETRIES + 1); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL nack_all_writes: got %0d missing expected 0", exp_q.size()); end
    nack_plan.delete();
  endtask

  task automatic test_nack_once();
    bit e_err, to; logic [AW-1:0] e_idx; logic b; int n;
    fill_rom_ff(); rom[0] = 24'h4E0A11; rom[1] = 24'h5433C0; rom[2] = 24'h8801FE;
    nack_plan.delete(); nack_plan.push_back(1'b0); nack_plan.push_back(1'b1);
    addr_writes = 0; expect_run(e_err, e_idx);
    pulse_start(b);
    wait_end(3000, n, to);
    checks++; if (to || done !== 1'b1 || error !== 1'b0) begin
      failures++; $display("FAIL nack_once_status: got done=%b err=%b expected 1/0", done, error); end
    checks++; if (addr_writes != 4) begin failures++; $display("FAIL nack_once_attempts: got %0d expected 4", addr_writes); end
    checks++; if (err_idx !== e_idx) begin failures++; $display("FAIL nack_once_idx: got %0d expected %0d", err_idx, e_idx); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL nack_once_writes: got %0d missing expected 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    bit to; logic b; int n;
    fill_rom_ff(); rom[0] = 24'h4EA611;
    exp_q.delete(); nack_plan.delete();
    wr_stall = 1'b1;
    pulse_start(b);
    wait_end(400, n, to);
    checks++; if (to || error !== 1'b1 || code !== 2'd2) begin
      failures++; $display("FAIL timeout_status: got err=%b code=%0d expected 1/2", error, code); end
    checks++; if (n < TIMEOUT - 5 || n > TIMEOUT + 10) begin
      failures++; $display("FAIL timeout_latency: got %0d cycles expected about %0d", n, TIMEOUT + 1); end
    checks++; if (bus.oPlbWrCE !== '0 || bus.oPlbRdCE !== '0 || busy !== 1'b0) begin
      failures++; $display("FAIL timeout_idle: got wr=%b rd=%b busy=%b expected 0", bus.oPlbWrCE, bus.oPlbRdCE, busy); end
    checks++; if (err_idx !== '0) begin failures++; $display("FAIL timeout_idx: got %0d expected 0", err_idx); end
    wr_stall = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit e_err, to; logic [AW-1:0] e_idx; logic b; int n;
    fill_rom_ff();
    for (int i = 0; i < 4; i++) rom[i] = {8'h20 + 8'(2 * i), 8'(i), 8'(8'h30 + i)};
    nack_plan.delete(); expect_run(e_err, e_idx);
    pulse_start(b);
    n = 0;
    while (!(dbg === ST_POLL2 && rom_addr === 8'd2) && n < 600) begin @(negedge clk); n++; end
    checks++; if (n >= 600) begin failures++; $display("FAIL reset_mid_reach: got no POLL2 of entry 2 expected within 600 cycles"); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || code !== 2'd0) begin
      failures++; $display("FAIL reset_mid_status: got busy=%b done=%b err=%b code=%0d expected 0", busy, done, error, code); end
    checks++; if (bus.oPlbWrCE !== '0 || bus.oPlbRdCE !== '0 || bus.oPlbData !== '0 || bus.oPlbBE !== '0) begin
      failures++; $display("FAIL reset_mid_bus: got wr=%b rd=%b expected 0", bus.oPlbWrCE, bus.oPlbRdCE); end
    checks++; if (rom_addr !== '0 || err_idx !== '0) begin
      failures++; $display("FAIL reset_mid_addr: got rom=%0d idx=%0d expected 0", rom_addr, err_idx); end
    @(negedge clk); exp_q.delete(); nack_plan.delete();
    @(negedge clk) rst_n = 1'b1;
    expect_run(e_err, e_idx);
    pulse_start(b);
    wait_end(3000, n, to);
    checks++; if (to || done !== 1'b1 || err_idx !== e_idx) begin
      failures++; $display("FAIL reset_mid_replay: got done=%b idx=%0d expected 1/%0d", done, err_idx, e_idx); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL reset_mid_writes: got %0d missing expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit e_err, to; logic [AW-1:0] e_idx; logic b; int n;
    fill_rom_ff(); rom[0] = 24'h4E1122; rom[1] = 24'h5A3344;
    nack_plan.delete(); expect_run(e_err, e_idx);
    pulse_start(b);
    repeat (15) @(negedge clk);
    pulse_start(b);
    wait_end(3000, n, to);
    checks++; if (to || done !== 1'b1 || exp_q.size() != 0) begin
      failures++; $display("FAIL b2b_first: got done=%b missing=%0d expected 1/0", done, exp_q.size()); end
    expect_run(e_err, e_idx);
    pulse_start(b);
    checks++; if (done !== 1'b0 || b !== 1'b1) begin
      failures++; $display("FAIL b2b_restart: got done=%b busy=%b expected 0/1", done, b); end
    wait_end(3000, n, to);
    checks++; if (to || done !== 1'b1 || exp_q.size() != 0) begin
      failures++; $display("FAIL b2b_second: got done=%b missing=%0d expected 1/0", done, exp_q.size()); end
    @(negedge clk) begin rst_n = 1'b0; start = 1'b1; end
    @(negedge clk) begin rst_n = 1'b1; start = 1'b0; end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || dbg !== 4'd0) begin
      failures++; $display("FAIL start_with_reset: got busy=%b state=%0d expected 0/0", busy, dbg); end
  endtask

  task automatic test_wrap();
    bit e_err, to; logic [AW-1:0] e_idx; logic b; int n;
    for (int i = 0; i < 256; i++)
      rom[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    nack_plan.delete(); expect_run(e_err, e_idx);
    pulse_start(b);
    wait_end(20000, n, to);
    checks++; if (to || done !== 1'b1 || error !== 1'b0) begin
      failures++; $display("FAIL wrap_status: got done=%b err=%b expected 1/0", done, error); end
    checks++; if (err_idx !== e_idx) begin failures++; $display("FAIL wrap_idx: got %0d expected %0d", err_idx, e_idx); end
    checks++; if (rom_addr !== 8'hFF) begin failures++; $display("FAIL wrap_no_wrap: got %0d expected 255", rom_addr); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_writes: got %0d missing expected 0", exp_q.size()); end
  endtask

  initial begin
    fill_rom_ff();
    test_reset();
    test_single_entry();
    test_empty_table();
    test_nack_all();
    test_nack_once();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before 90000 cycles");
    $fatal(1, "watchdog expired");
  end
endmodule
